artemis_rst_sequencer: RTL

Parametrised power-up and reset sequencer for the Artemis infrastructure layer. It replaces the fixed AND of board and adapter resets with the following:
- N synchronised active-low reset sources.
- A PLL reset/lock phase.
- A DDR3 reset/calibration phase with timeout and bounded retry.
- A gated system reset.
It sits between the board/adapter reset pins, the clock generator's lock output and the DDR3 controller's calibration flag, and drives the resets of both cores and of user logic.

---
 rtl/artemis_rst_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/artemis_rst_sequencer.sv
// Power-up / reset sequencer: source synchronisers, PLL reset/lock, DDR3 reset/calibration, gated user reset.
// Optional status outputs (lock_loss_count, last_cal_cycles) are built when ARTEMIS_RST_SEQ_STATUS_EN is defined.
`timescale 1ns/1ps
module artemis_rst_sequencer #(
    parameter int NUM_RST_SRC         = 2,
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int DDR_RST_CYCLES      = 64,
    parameter int CAL_TIMEOUT_CYCLES  = 1048576,
    parameter int MAX_RETRIES         = 3,
    parameter int CNTR_WIDTH          = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RST_SRC-1:0] rst_src_n,
    input  logic                   pll_locked,
    input  logic                   calibration_done,
    output logic                   pll_rst,
    output logic                   ddr3_rst_req,
    output logic                   sys_rst,
    output logic                   ready,
    output logic                   cal_fail,
    output logic [2:0]             seq_state,
    output logic [1:0]             retry_count
`ifdef ARTEMIS_RST_SEQ_STATUS_EN
    ,
    output logic [7:0]             lock_loss_count,
    output logic [CNTR_WIDTH-1:0]  last_cal_cycles
`endif
);

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_PLL_RST  = 3'd1,
        ST_PLL_WAIT = 3'd2,
        ST_DDR_RST  = 3'd3,
        ST_CAL_WAIT = 3'd4,
        ST_RUN      = 3'd5,
        ST_FAIL     = 3'd6
    } state_t;

    localparam int SYNC_W = NUM_RST_SRC + 2;

    localparam logic [CNTR_WIDTH-1:0] PLL_RST_LAST  = CNTR_WIDTH'(PLL_RST_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] LOCK_TO_LAST  = CNTR_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] DDR_RST_LAST  = CNTR_WIDTH'(DDR_RST_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] CAL_TO_LAST   = CNTR_WIDTH'(CAL_TIMEOUT_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] CNTR_MAX      = '1;
    localparam logic [1:0]            MAX_RETRY_V   = 2'(MAX_RETRIES);

    // Synchroniser chains: sources in the low bits, then lock, then calibration.
    logic [SYNC_W-1:0] r_sync [SYNC_STAGES];
    logic [SYNC_W-1:0] w_sync_out;
    logic              w_src_ok;
    logic              w_lock_s;
    logic              w_cal_s;

    // NOTE: the chain is a handful of flops, not a RAM, so every stage is reset to a known 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= {calibration_done, pll_locked, rst_src_n};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_src_ok   = &w_sync_out[NUM_RST_SRC-1:0];
    assign w_lock_s   = w_sync_out[NUM_RST_SRC];
    assign w_cal_s    = w_sync_out[NUM_RST_SRC+1];

    state_t                r_state;
    logic [CNTR_WIDTH-1:0] r_counter;
    state_t                w_next_state;
    logic                  w_retry_inc;
    logic                  w_retry_clr;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
        if (!w_src_ok) begin
            w_next_state = ST_RESET;
        end else begin
            case (r_state)
                ST_RESET: begin
                    w_next_state = ST_PLL_RST;
                    w_retry_clr  = 1'b1;
                end
                ST_PLL_RST: begin
                    if (r_counter == PLL_RST_LAST) begin
                        w_next_state = ST_PLL_WAIT;
                    end
                end
                ST_PLL_WAIT: begin
                    if (w_lock_s) begin
                        w_next_state = ST_DDR_RST;
                    end else if (r_counter == LOCK_TO_LAST) begin
                        if (retry_count == MAX_RETRY_V) begin
                            w_next_state = ST_FAIL;
                        end else begin
                            w_next_state = ST_PLL_RST;
                            w_retry_inc  = 1'b1;
                        end
                    end
                end
                ST_DDR_RST: begin
                    if (r_counter == DDR_RST_LAST) begin
                        w_next_state = ST_CAL_WAIT;
                    end
                end
                ST_CAL_WAIT: begin
                    // Losing the clock invalidates any calibration result, so it is checked first.
                    if (!w_lock_s) begin
                        w_next_state = ST_PLL_RST;
                    end else if (w_cal_s) begin
                        w_next_state = ST_RUN;
                    end else if (r_counter == CAL_TO_LAST) begin
                        if (retry_count == MAX_RETRY_V) begin
                            w_next_state = ST_FAIL;
                        end else begin
                            w_next_state = ST_DDR_RST;
                            w_retry_inc  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        w_next_state = ST_PLL_RST;
                    end else if (!w_cal_s) begin
                        w_next_state = ST_DDR_RST;
                    end
                end
                ST_FAIL: begin
                    w_next_state = ST_FAIL;
                end
                default: begin
                    w_next_state = ST_RESET;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the entry edge, glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_RESET;
            r_counter    <= '0;
            retry_count  <= '0;
            pll_rst      <= 1'b1;
            ddr3_rst_req <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            cal_fail     <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_next_state != r_state) begin
                r_counter <= '0;
            end else if (r_counter != CNTR_MAX) begin
                r_counter <= r_counter + 1'b1;
            end

            if (w_retry_clr) begin
                retry_count <= '0;
            end else if (w_retry_inc && (retry_count != 2'b11)) begin
                retry_count <= retry_count + 1'b1;
            end

            pll_rst      <= (w_next_state inside {ST_RESET, ST_PLL_RST, ST_FAIL});
            ddr3_rst_req <= !(w_next_state inside {ST_CAL_WAIT, ST_RUN});
            sys_rst      <= (w_next_state != ST_RUN);
            ready        <= (w_next_state == ST_RUN);
            cal_fail     <= (w_next_state == ST_FAIL);
        end
    end

    assign seq_state = r_state;

`ifdef ARTEMIS_RST_SEQ_STATUS_EN
    logic r_lock_d;
    logic w_lock_fall;

    assign w_lock_fall = r_lock_d && !w_lock_s &&
                         ((r_state == ST_CAL_WAIT) || (r_state == ST_RUN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_d        <= 1'b0;
            lock_loss_count <= '0;
            last_cal_cycles <= '0;
        end else begin
            r_lock_d <= w_lock_s;
            if (w_lock_fall && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
            if ((r_state == ST_CAL_WAIT) && (w_next_state == ST_RUN)) begin
                last_cal_cycles <= r_counter;
            end
        end
    end
`else
    // Status counters are not built in this configuration.
`endif

endmodule
